// File: rtl/spart_wr_pkg.sv
// Shared state type and default parameters for the SPART SDRAM writer.
package spart_wr_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StDone} wr_state_e;

   localparam int unsigned DefDepth      = 8;
   localparam int unsigned DefAddrW      = 23;
   localparam int unsigned DefFrameWords = 4096;
   localparam int unsigned DefBaseAddr   = 0;
   localparam int unsigned CntW          = 24;

endpackage

// File: rtl/spart_sync_fifo.sv
// Synchronous FIFO with flush, combinational head word and registered occupancy.
module spart_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned LvlW = PtrW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [LvlW-1:0]  level,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [LvlW-1:0]  level_q;
   logic             do_push, do_pop;

   // Full is judged on the start-of-cycle level, so a same-cycle pop never frees a slot.
   assign full    = (level_q == LvlW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem_q[rptr_q];
   assign level   = level_q;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         level_q <= level_q + LvlW'(do_push) - LvlW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/spart_sdram_writer.sv
// Buffers SPART words and writes them to SDRAM at consecutive frame addresses.
// Define SPART_WR_CHECKSUM_EN to build the per-frame frame_sum accumulator.
module spart_sdram_writer
   import spart_wr_pkg::*;
#(
   parameter int unsigned DEPTH       = DefDepth,
   parameter int unsigned ADDR_W      = DefAddrW,
   parameter int unsigned FRAME_WORDS = DefFrameWords,
   parameter int unsigned BASE_ADDR   = DefBaseAddr,
   localparam int unsigned LvlW       = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       iWord,
   input  logic              iwordVAL,
   input  logic              clear,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   input  logic              wr_ack,
   output logic              frame_done,
   output logic              overflow,
   output logic [LvlW-1:0]   fifo_level,
   output logic [15:0]       frame_sum
);

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [CntW-1:0]   LastIdx  = CntW'(FRAME_WORDS - 1);

   wr_state_e         state_q, state_d;
   logic              wr_req_q, wr_req_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr_cnt_q, addr_cnt_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [CntW-1:0]   word_cnt_q, word_cnt_d;
   logic              clr_pend_q, clr_pend_d, overflow_q, overflow_d;

   logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
   logic [15:0]       fifo_head;
   logic              req_ack, clr_apply, complete;

   // A clear seen during REQ waits for the ack and then replaces the normal completion.
   assign req_ack    = (state_q == StReq) & wr_ack;
   assign clr_apply  = ((state_q != StReq) & clear) | (req_ack & (clr_pend_q | clear));
   assign complete   = req_ack & ~clr_apply;
   assign fifo_push  = iwordVAL & ~clear;
   assign fifo_pop   = req_ack;
   assign fifo_flush = clr_apply;

   spart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .wdata (iWord),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .level (fifo_level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      state_d    = state_q;
      wr_req_d   = wr_req_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      addr_cnt_d = addr_cnt_q;
      word_cnt_d = word_cnt_q;
      clr_pend_d = clr_pend_q;
      overflow_d = overflow_q | (fifo_push & fifo_full);
      unique case (state_q)
         StIdle: begin
            if (!clear && !fifo_empty) begin
               wr_req_d  = 1'b1;
               wr_addr_d = addr_cnt_q;
               wr_data_d = fifo_head;
               state_d   = StReq;
            end
         end
         StReq: begin
            if (clear) clr_pend_d = 1'b1;
            if (req_ack) begin
               wr_req_d = 1'b0;
               state_d  = StIdle;
               if (complete) begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  addr_cnt_d = addr_cnt_q + 1'b1;
                  if (word_cnt_q == LastIdx) state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d    = StIdle;
            word_cnt_d = '0;
            addr_cnt_d = BaseAddr;
            wr_addr_d  = BaseAddr;
         end
         default: state_d = StIdle;
      endcase
      if (clr_apply) begin
         clr_pend_d = 1'b0;
         word_cnt_d = '0;
         addr_cnt_d = BaseAddr;
         wr_addr_d  = BaseAddr;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         wr_req_q   <= 1'b0;
         wr_addr_q  <= BaseAddr;
         wr_data_q  <= '0;
         addr_cnt_q <= BaseAddr;
         word_cnt_q <= '0;
         clr_pend_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_req_q   <= wr_req_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         addr_cnt_q <= addr_cnt_d;
         word_cnt_q <= word_cnt_d;
         clr_pend_q <= clr_pend_d;
         overflow_q <= overflow_d;
      end
   end

   assign wr_req     = wr_req_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign overflow   = overflow_q;
   assign frame_done = (state_q == StDone);

`ifdef SPART_WR_CHECKSUM_EN
   logic [15:0] sum_q;

   // Holds the frame total through DONE, then restarts for the next frame.
   always_ff @(posedge clk) begin
      if (!rst || clr_apply || state_q == StDone) begin
         sum_q <= '0;
      end else if (complete) begin
         sum_q <= sum_q + wr_data_q;
      end
   end

   assign frame_sum = sum_q;
`else
   assign frame_sum = '0;
`endif

endmodule
